// File: rtl/v74x139_pkg.sv
// Shared types and the pure 2-to-4 active-low decode used by the v74x139 decoder.
package v74x139_pkg;

    localparam logic [3:0] Y_IDLE = 4'b1111;

    typedef logic [1:0] sel_t;

    // Active-low one-cold decode: disabled gives all ones, enabled clears bit sel.
    function automatic logic [3:0] decode_y(input logic g_l, input sel_t sel);
        logic [3:0] y;
        if (g_l) begin
            y = Y_IDLE;
        end else begin
            y = ~(4'b0001 << sel);
        end
        return y;
    endfunction

endpackage

// File: rtl/v74x139_dec_core.sv
// Combinational core of one half of a 74x139: enable plus 2-bit select to one-cold output.
module v74x139_dec_core
    import v74x139_pkg::*;
(
    input  logic       G_L,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Y_L
);

    sel_t sel;

    assign sel = {B, A};
    assign Y_L = decode_y(G_L, sel);

endmodule

// File: rtl/v74x139_behavior.sv
// 74x139 decoder top; define V74X139_REG_OUT_EN for a registered output with one cycle of latency.
module v74x139_behavior
    import v74x139_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       G_L,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Y_L
);

    logic [3:0] dec_y;

    v74x139_dec_core u_dec_core (
        .G_L (G_L),
        .A   (A),
        .B   (B),
        .Y_L (dec_y)
    );

`ifdef V74X139_REG_OUT_EN
    logic [3:0] y_reg;

    // Async reset parks the outputs at idle, so no bit is ever driven low while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg <= Y_IDLE;
        end else begin
            y_reg <= dec_y;
        end
    end

    assign Y_L = y_reg;
`else
    logic unused_clk;

    assign unused_clk = clk;
    assign Y_L = rst ? Y_IDLE : dec_y;
`endif

endmodule

// File: tb/tb_v74x139_behavior.sv
// Self-checking scoreboard bench for v74x139_behavior; follows V74X139_REG_OUT_EN for latency.
module tb_v74x139_behavior;

    logic       clk;
    logic       rst;
    logic       G_L;
    logic       A;
    logic       B;
    logic [3:0] Y_L;

    int errors;
    int checks;

    logic [3:0] exp_q[$];

    v74x139_behavior dut (
        .clk (clk),
        .rst (rst),
        .G_L (G_L),
        .A   (A),
        .B   (B),
        .Y_L (Y_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference table for the decoder.
    function automatic logic [3:0] model_y(input logic g, input logic b, input logic a);
        logic [3:0] y;
        if (g) begin
            y = 4'b1111;
        end else begin
            case ({b, a})
                2'b00:   y = 4'b1110;
                2'b01:   y = 4'b1101;
                2'b10:   y = 4'b1011;
                default: y = 4'b0111;
            endcase
        end
        return y;
    endfunction

    function automatic logic [3:0] count_zeros(input logic [3:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == 1'b0) n = n + 4'd1;
        end
        return n;
    endfunction

    task automatic check_output(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Waits out the configured latency, then pops the oldest expectation and compares.
    task automatic wait_and_compare(input string tag);
        logic [3:0] exp_y;
`ifdef V74X139_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        if (exp_q.size() == 0) begin
            check_output({tag, "_sb_empty"}, Y_L, 4'bxxxx);
        end else begin
            exp_y = exp_q.pop_front();
            check_output(tag, Y_L, exp_y);
        end
    endtask

    task automatic apply_stimulus(input logic g, input logic b, input logic a);
        @(negedge clk);
        G_L = g;
        B   = b;
        A   = a;
        exp_q.push_back(model_y(g, b, a));
    endtask

    initial begin
        logic [3:0] exp_y;
        logic       g, b, a;

        errors = 0;
        checks = 0;
        rst = 1'b1;
        G_L = 1'b1;
        A   = 1'b0;
        B   = 1'b0;

        #2;
        check_output("reset_idle", Y_L, 4'b1111);
        @(negedge clk);
        G_L = 1'b0;
        #1;
        check_output("reset_hold_enabled", Y_L, 4'b1111);
        G_L = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, i[1], i[0]);
            wait_and_compare($sformatf("enabled_sel%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, i[1], i[0]);
            wait_and_compare($sformatf("disabled_sel%0d", i));
        end

        // Assert reset between edges: the output must go idle with no clock.
        apply_stimulus(1'b0, 1'b1, 1'b1);
        wait_and_compare("pre_async_rst");
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_no_edge", Y_L, 4'b1111);
        @(posedge clk);
        #1;
        check_output("async_rst_held", Y_L, 4'b1111);

        @(negedge clk);
        G_L = 1'b0;
        B   = 1'b1;
        A   = 1'b0;
        rst = 1'b0;
        #1;
`ifdef V74X139_REG_OUT_EN
        check_output("rst_release_before_edge", Y_L, 4'b1111);
`else
        check_output("rst_release_comb", Y_L, 4'b1011);
`endif
        @(posedge clk);
        #1;
        check_output("rst_release_after_edge", Y_L, 4'b1011);

        for (int i = 0; i < 1000; i++) begin
            g = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            apply_stimulus(g, b, a);
            wait_and_compare("random_value");
            exp_y = {3'b000, ~g};
            check_output("random_zero_count", count_zeros(Y_L), exp_y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/v74x139_behavior.md
V74X139_BEHAVIOR -- requirements
Module: v74x139_behavior

Interface
REQ-001 SHALL have no parameters; the idle output value is the package constant Y_IDLE = 4'b1111.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all registers use its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 SHALL have port G_L, input, 1 bit, the enable, active-low.
REQ-005 SHALL have port A, input, 1 bit, the select LSB.
REQ-006 SHALL have port B, input, 1 bit, the select MSB.
REQ-007 SHALL have port Y_L, output, 4 bits, the decoded outputs, active-low, one-cold.

Function
REQ-008 SHALL define the select index as sel = {B, A}, a 2-bit unsigned value (0..3).
REQ-009 SHALL, when G_L=0, drive the decoded value Y_L[sel]=0 and every other Y_L bit to 1.
- sel=0 gives 4'b1110.
- sel=1 gives 4'b1101.
- sel=2 gives 4'b1011.
- sel=3 gives 4'b0111.
REQ-010 SHALL, when G_L=1, decode to 4'b1111 regardless of A and B.
REQ-011 SHALL never produce more than one 0 bit in Y_L, including across reset deassertion.
REQ-012 SHALL treat X/Z on G_L, A or B as don't-care for synthesis; there are no other inputs or side effects.
REQ-013 SHALL, with registration enabled (REQ-018), present the decode of the inputs sampled at rising edge N on Y_L after edge N: exactly 1 cycle of latency, updated every cycle, with no handshake.
REQ-014 SHALL, with registration disabled, drive Y_L combinationally with 0 cycles of latency.

Reset
REQ-015 SHALL force Y_L=4'b1111 immediately (asynchronously) while rst=1, in both configurations.
REQ-016 SHALL, in registered mode, load the decode of the current inputs at the first rising clk edge after rst falls; until then Y_L stays 4'b1111.
REQ-017 SHALL, when rst asserts mid-operation, override any active output within the same cycle, with no clock needed.

Configuration
REQ-018 SHALL use macro V74X139_REG_OUT_EN.
- When defined: Y_L comes from a 4-bit output register (REQ-013, REQ-016).
- When undefined: Y_L = rst ? 4'b1111 : decode(G_L, B, A), fully combinational, and clk is unused.

Structure
REQ-019 SHALL place the following in package v74x139_pkg:
- constant Y_IDLE = 4'b1111;
- a sel_t 2-bit typedef;
- a pure decode function (G_L, sel) -> 4-bit active-low vector.
REQ-020 SHALL implement the decode in one combinational sub-module, v74x139_dec_core (inputs G_L, A, B; output Y_L), instantiated once.
REQ-021 SHALL keep the output register, the reset muxing and the macro selection in v74x139_behavior.

Verification
REQ-022 SHALL cover the following directed scenarios:
- Enabled sweep: G_L=0 with {B,A}=00,01,10,11 -> Y_L=1110, 1101, 1011, 0111 (registered mode: one edge later).
- Disabled sweep: G_L=1 with all four {B,A} -> Y_L=1111 for each.
- Async reset: G_L=0, B=1, A=1, Y_L=0111, then rst=1 between edges -> Y_L=1111 with no edge; it remains 1111 while rst=1.
- Reset release (registered): rst falls with G_L=0, {B,A}=10 -> Y_L=1111 until the next rising edge, then 1011.
- One-cold check: random G_L/A/B for 1000 cycles -> the number of zeros in Y_L is never above 1 and equals ~G_L (of the previous cycle in registered mode).
- Build both with and without V74X139_REG_OUT_EN -> latency is 1 and 0 cycles respectively, with identical decoded values.
